// File: rtl/booth_ctrl.sv
// ---------------------------------------------------------------------------
// booth_ctrl
//
// Control FSM for the 16-bit radix-2 Booth multiplier. Drives every strobe of
// booth_datapath: operand capture from the shared data_in bus (multiplicand
// first, then multiplier), then 16 evaluate/shift iterations, then a level
// done that holds until the requester drops start.
//
// Ports
//   clk     in   single clock, rising edge
//   reset   in   synchronous, active-high (shared with booth_datapath)
//   start   in   operation request, sampled only in IDLE
//   q0      in   datapath Q[0]
//   qm1     in   datapath Q[-1] flop
//   eqz     in   datapath iteration counter == 0
//   LdA     out  load A with A+M / A-M
//   LdQ     out  load Q from data_in (multiplier)
//   LdM     out  load M from data_in (multiplicand)
//   clrA    out  clear A
//   clrQ    out  clear Q (unused, tied low: LdQ overwrites Q)
//   clrff   out  clear the Q[-1] flop
//   sftA    out  arithmetic right shift of A
//   sftQ    out  right shift of Q (A[0] enters Q[15])
//   addsub  out  1 = A+M, 0 = A-M
//   decr    out  decrement iteration counter
//   ldcnt   out  load iteration counter with 16
//   busy    out  high in LOAD_M, LOAD_Q, EVAL, SHIFT
//   done    out  high while in DONE
//
// Timing from the edge that samples start in IDLE (cycle 0): LOAD_M in
// cycle 1, LOAD_Q in cycle 2, 16 EVAL/SHIFT pairs in cycles 3..34, the
// terminating EVAL in cycle 35, done from cycle 36 onward.
// ---------------------------------------------------------------------------
module booth_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
    output logic LdA,
    output logic LdQ,
    output logic LdM,
    output logic clrA,
    output logic clrQ,
    output logic clrff,
    output logic sftA,
    output logic sftQ,
    output logic addsub,
    output logic decr,
    output logic ldcnt,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_M = 3'd1,
        S_LOAD_Q = 3'd2,
        S_EVAL   = 3'd3,
        S_SHIFT  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state;

    // High only in the cycle(s) directly following a reset edge, so that the
    // otherwise always-high addsub reads 0 together with every other output.
    logic rst_q;

    // EVAL decisions depend on the datapath bits produced by the preceding
    // SHIFT edge, so they cannot be precomputed into a register; they are
    // decoded combinationally from the current state and status inputs.
    logic in_eval;
    logic do_sub;
    logic do_add;

    assign in_eval = (state == S_EVAL) && !eqz;
    assign do_sub  = in_eval &&  q0 && !qm1;   // {q0,qm1} = 10 : A <- A - M
    assign do_add  = in_eval && !q0 &&  qm1;   // {q0,qm1} = 01 : A <- A + M

    assign LdA    = do_sub | do_add;
    // addsub only matters while LdA is high; elsewhere it idles at 1.
    assign addsub = !rst_q && !do_sub;
    // LOAD_Q overwrites Q, so Q never needs an explicit clear.
    assign clrQ   = 1'b0;

    // State register and all Moore strobes. Each strobe is registered from
    // the state being entered, so it is high for exactly the cycle spent in
    // that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            rst_q <= 1'b1;
            LdQ   <= 1'b0;
            LdM   <= 1'b0;
            clrA  <= 1'b0;
            clrff <= 1'b0;
            sftA  <= 1'b0;
            sftQ  <= 1'b0;
            decr  <= 1'b0;
            ldcnt <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            rst_q <= 1'b0;
            LdQ   <= 1'b0;
            LdM   <= 1'b0;
            clrA  <= 1'b0;
            clrff <= 1'b0;
            sftA  <= 1'b0;
            sftQ  <= 1'b0;
            decr  <= 1'b0;
            ldcnt <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD_M;
                        LdM   <= 1'b1;
                        clrA  <= 1'b1;
                        ldcnt <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                S_LOAD_M: begin
                    state <= S_LOAD_Q;
                    LdQ   <= 1'b1;
                    clrff <= 1'b1;
                    busy  <= 1'b1;
                end

                S_LOAD_Q: begin
                    state <= S_EVAL;
                    busy  <= 1'b1;
                end

                // The Q[-1] flop reloads from Q[0] on every non-cleared edge,
                // so EVAL must be followed directly by SHIFT: any extra cycle
                // would overwrite qm1 with the already-consumed Q[0].
                S_EVAL: begin
                    if (eqz) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                        sftA  <= 1'b1;
                        sftQ  <= 1'b1;
                        decr  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    state <= S_EVAL;
                    busy  <= 1'b1;
                end

                // Level done; a held start never restarts the multiplier.
                S_DONE: begin
                    if (start) begin
                        done <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_ctrl.sv
module tb_booth_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        q0;
    logic        qm1;
    logic        eqz;
    logic        LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ;
    logic        addsub, decr, ldcnt, busy, done;

    booth_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .q0     (q0),
        .qm1    (qm1),
        .eqz    (eqz),
        .LdA    (LdA),
        .LdQ    (LdQ),
        .LdM    (LdM),
        .clrA   (clrA),
        .clrQ   (clrQ),
        .clrff  (clrff),
        .sftA   (sftA),
        .sftQ   (sftQ),
        .addsub (addsub),
        .decr   (decr),
        .ldcnt  (ldcnt),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural booth_datapath. A carries one guard bit so that the
    // -32768 x -32768 case stays exact.
    logic        [15:0] mcand;
    logic        [15:0] mplier;
    logic        [15:0] data_in;
    logic        [15:0] M_r;
    logic        [15:0] Q_r;
    logic signed [16:0] A_r;
    logic signed [16:0] m_ext;
    logic               qm1_r;
    logic        [4:0]  cnt_r;

    assign data_in = LdM ? mcand : (LdQ ? mplier : 16'h0000);
    assign m_ext   = {M_r[15], M_r};
    assign q0      = Q_r[0];
    assign qm1     = qm1_r;
    assign eqz     = (cnt_r == 5'd0);

    always @(posedge clk) begin
        if (reset) begin
            M_r   <= 16'h0000;
            Q_r   <= 16'h0000;
            A_r   <= 17'sd0;
            qm1_r <= 1'b0;
            cnt_r <= 5'd0;
        end else begin
            if (LdM) M_r <= data_in;
            if (clrA)       A_r <= 17'sd0;
            else if (LdA)   A_r <= addsub ? (A_r + m_ext) : (A_r - m_ext);
            else if (sftA)  A_r <= {A_r[16], A_r[16:1]};
            if (LdQ)        Q_r <= data_in;
            else if (sftQ)  Q_r <= {A_r[0], Q_r[15:1]};
            if (clrff)      qm1_r <= 1'b0;
            else            qm1_r <= Q_r[0];
            if (ldcnt)      cnt_r <= 5'd16;
            else if (decr)  cnt_r <= cnt_r - 5'd1;
        end
    end

    logic [12:0] dut_vec;
    assign dut_vec = {LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ,
                      addsub, decr, ldcnt, busy, done};

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected output vector in cycle k of a run (k = 0 means IDLE,
    // k >= 36 means DONE). q/qm are the datapath status bits in that cycle.
    function automatic logic [12:0] exp_vec(input int k, input logic q, input logic qm);
        logic lda, ldq, ldm, clra, clrf, sft, asub, dec, ldc, bsy, dn;
        lda = 0; ldq = 0; ldm = 0; clra = 0; clrf = 0; sft = 0;
        asub = 1; dec = 0; ldc = 0; bsy = 0; dn = 0;
        if (k == 1) begin
            ldm = 1; clra = 1; ldc = 1; bsy = 1;
        end else if (k == 2) begin
            ldq = 1; clrf = 1; bsy = 1;
        end else if (k >= 3 && k <= 33 && (k % 2) == 1) begin
            bsy  = 1;
            lda  = q ^ qm;
            asub = !(q && !qm);
        end else if (k >= 4 && k <= 34 && (k % 2) == 0) begin
            sft = 1; dec = 1; bsy = 1;
        end else if (k == 35) begin
            bsy = 1;
        end else if (k >= 36) begin
            dn = 1;
        end
        return {lda, ldq, ldm, clra, 1'b0, clrf, sft, sft, asub, dec, ldc, bsy, dn};
    endfunction

    // Full run, entered just after a negedge with the DUT in IDLE.
    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                          input logic [31:0] prod, input bit hold);
        mcand  = mc;
        mplier = mp;
        start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) start = 1'b0;
            chk($sformatf("strobes %h*%h c%0d", mc, mp, k),
                {19'd0, dut_vec}, {19'd0, exp_vec(k, Q_r[0], qm1_r)});
            if (k == 36)
                chk($sformatf("product %h*%h", mc, mp), {A_r[15:0], Q_r}, prod);
        end
        if (!hold) begin
            @(negedge clk);
            chk($sformatf("idle after %h*%h", mc, mp),
                {19'd0, dut_vec}, {19'd0, exp_vec(0, 1'b0, 1'b0)});
        end
    endtask

    typedef struct {
        logic [15:0] mc;
        logic [15:0] mp;
        logic [31:0] prod;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        tbl[0] = '{16'h0005, 16'h0003, 32'h0000000F};
        tbl[1] = '{16'hFFFB, 16'h0003, 32'hFFFFFFF1};
        tbl[2] = '{16'h0007, 16'hFFFC, 32'hFFFFFFE4};
        tbl[3] = '{16'h8000, 16'h8000, 32'h40000000};
        tbl[4] = '{16'h7FFF, 16'h8000, 32'hC0008000};

        reset  = 1'b1;
        start  = 1'b0;
        mcand  = 16'h0000;
        mplier = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {19'd0, dut_vec}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle after reset", {19'd0, dut_vec}, {19'd0, exp_vec(0, 1'b0, 1'b0)});

        for (int i = 0; i < 5; i++)
            run_op(tbl[i].mc, tbl[i].mp, tbl[i].prod, 1'b0);

        // Reset asserted during cycle 20 of a run.
        mcand  = 16'h1234;
        mplier = 16'h5678;
        start  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk($sformatf("strobes pre-abort c%0d", k),
                {19'd0, dut_vec}, {19'd0, exp_vec(k, Q_r[0], qm1_r)});
        end
        reset = 1'b1;
        @(negedge clk);
        chk("abort outputs", {19'd0, dut_vec}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        chk("abort no busy/done", seen, 0);
        chk("abort idle", {19'd0, dut_vec}, {19'd0, exp_vec(0, 1'b0, 1'b0)});
        run_op(16'h0005, 16'h0003, 32'h0000000F, 1'b0);

        // start held high through DONE.
        run_op(16'h0007, 16'hFFFC, 32'hFFFFFFE4, 1'b1);
        for (int k = 37; k <= 39; k++) begin
            @(negedge clk);
            chk($sformatf("done hold c%0d", k),
                {19'd0, dut_vec}, {19'd0, exp_vec(36, 1'b0, 1'b0)});
        end
        chk("product held", {A_r[15:0], Q_r}, 32'hFFFFFFE4);
        start = 1'b0;
        @(negedge clk);
        chk("idle after drop", {19'd0, dut_vec}, {19'd0, exp_vec(0, 1'b0, 1'b0)});
        run_op(16'hFFFB, 16'h0003, 32'hFFFFFFF1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Control FSM for the 16-bit radix-2 Booth multiplier. It sits directly upstream of `booth_datapath` and drives every load, clear, shift, add/sub and count strobe the datapath needs. It sequences operand capture from the shared `data_in` bus and runs the 16 evaluate/shift iterations, using the datapath status bits `q0`, `qm1` and `eqz`. It signals completion to the requester with a level `done`; the 32-bit product is then `{A,Q}` in the datapath.

## Interface
Parameters:
- None. The iteration count is fixed by the datapath counter load value of 16.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high; shared with `booth_datapath`
- `start`  in  1  request from the upstream requester; sampled in IDLE
- `q0`  in  1  datapath Q[0]
- `qm1`  in  1  datapath Q[-1] flop
- `eqz`  in  1  datapath counter == 0
- `LdA`, `LdQ`, `LdM`  out  1 each  register load strobes
- `clrA`, `clrQ`, `clrff`  out  1 each  register clears
- `sftA`, `sftQ`  out  1 each  arithmetic shift strobes
- `addsub`  out  1  1 = A+M, 0 = A−M
- `decr`, `ldcnt`  out  1 each  counter decrement / load-16
- `busy`  out  1  high in every state except IDLE and DONE
- `done`  out  1  high while in DONE

## Operation
- States: IDLE, LOAD_M, LOAD_Q, EVAL, SHIFT, DONE. The encoding is free.
- Output defaults: every strobe is 0 unless listed for the current state.
- IDLE
  - Outputs: none asserted.
  - Transition: `start`=1 → LOAD_M; otherwise stay in IDLE.
- LOAD_M
  - Outputs: `LdM`=1, `clrA`=1, `ldcnt`=1.
  - Data: the requester drives the multiplicand on `data_in` this cycle.
  - Transition: → LOAD_Q.
- LOAD_Q
  - Outputs: `LdQ`=1, `clrff`=1.
  - Data: the requester drives the multiplier on `data_in` this cycle.
  - Effect: Q[-1] is cleared to 0.
  - Transition: → EVAL.
- EVAL (outputs are Mealy on `q0`, `qm1`, `eqz`)
  - `eqz`=1: no strobes; → DONE.
  - `{q0,qm1}`=2'b10: `LdA`=1, `addsub`=0 (A←A−M); → SHIFT.
  - `{q0,qm1}`=2'b01: `LdA`=1, `addsub`=1 (A←A+M); → SHIFT.
  - `{q0,qm1}` = 00 or 11: no strobes; → SHIFT.
- SHIFT
  - Outputs: `sftA`=1, `sftQ`=1, `decr`=1.
  - Effect: the Q[-1] flop captures the pre-shift Q[0] on this edge.
  - Transition: → EVAL.
- DONE
  - Outputs: `done`=1.
  - Transition: `start`=0 → IDLE. If `start` stays high, remain in DONE; no automatic restart. The requester must drop `start` and raise it again.
- The Q[-1] flop in the datapath reloads from Q[0] on every non-cleared edge. For that reason exactly one cycle (EVAL) separates consecutive shifts, and the decision in EVAL always uses the `qm1` captured at the previous SHIFT edge, or the 0 from LOAD_Q. No extra wait states may be inserted between EVAL and SHIFT.
- `clrQ` is never asserted, because LOAD_Q overwrites Q.
- `addsub` is 1 in every cycle where `LdA`=0. This is a don't-care, but it is fixed for waveform stability.
- Arithmetic is two's complement throughout. The product is signed 32-bit `{A,Q}` and is valid for all 16-bit operand pairs, including −32768 × −32768.

## Timing
- Reset: state → IDLE; every output is 0 on the cycle after the reset edge. This includes `busy`, `done` and all strobes.
- Reset mid-operation has the same effect. The datapath is cleared by the same reset, and the aborted operation produces no `done`.
- Cycle numbering: cycle 0 is the edge at which `start` is sampled in IDLE.
- Latency from that edge:
  - Cycle 1: LOAD_M.
  - Cycle 2: LOAD_Q.
  - Cycles 3–34: 16 EVAL/SHIFT pairs.
  - Cycle 35: EVAL sees `eqz`=1.
  - Cycle 36: `done` rises.
- The latency is fixed at 36 cycles regardless of operand values.
- `busy` is high for cycles 1–35.
- `start` pulses while busy are ignored.
- `{A,Q}` is stable for the whole time `done` is high.

## Test plan
- **5 × 3.** Multiplicand 0x0005, multiplier 0x0003. Required: product 0x0000000F; `done` rises exactly 36 cycles after `start` is sampled.
- **Negative multiplicand.** −5 (0xFFFB) × 3. Required: 0xFFFFFFF1; `LdA` pulses only in EVAL cycles where `{q0,qm1}` is 10 or 01.
- **Negative multiplier.** 7 × −4 (0xFFFC). Required: 0xFFFFFFE4.
- **Extreme operands.**
  - 0x8000 × 0x8000 → 0x40000000.
  - 0x7FFF × 0x8000 → 0xC0008000.
- **Reset mid-run.** Assert `reset` in cycle 20 of a run. Required: all outputs are 0 on the next cycle and the state is IDLE; a following 5 × 3 run completes correctly.
- **`start` held high.** Keep `start` high through DONE. Required: `done` stays high with no restart. Drop `start`: IDLE follows one cycle later. Raise `start` again: a new run begins.
